fp_mul_seq_core: RTL and testbench
==================================

FP_MUL_SEQ_CORE -- requirements
Module: fp_mul_seq_core

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the operand/result width; only 32 (IEEE-754 single) is supported.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high. The ports SHALL be:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  request; sampled only in IDLE.
- float_num1  in  32  operand A.
- float_num2  in  32  operand B.
- exc_sel  in  1  from the multiplication exception stage: 0 = use exc_out, 1 = compute.
- exc_out  in  32  exception-stage result.
- busy  out  1  high in MULT and NORM.
- done  out  1  one-cycle pulse; result is valid.
- result  out  32  product; held until the next accepted start.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, MULT, NORM and DONE.
REQ-004 In IDLE with start=1 and exc_sel=0, the block SHALL do the following at that edge: load result with exc_out and go to DONE (bypass).
REQ-005 In IDLE with start=1 and exc_sel=1, the block SHALL latch the operands at that edge and handle them as follows:
- If either exponent field is 0, load result with a signed zero (sign = sA^sB) and go to DONE.
- Else, if either exponent field is 255, load result with a signed infinity and go to DONE. Zero has priority; NaN payloads are ignored.
- Otherwise go to MULT.
REQ-006 On entry to MULT the block SHALL set up the datapath as follows:
- sign = sA^sB.
- A 10-bit signed exponent = eA+eB-127.
- Mantissas are 24-bit with the hidden 1.
- A 48-bit accumulator is cleared.
- A 5-bit iteration counter is cleared.
REQ-007 MULT SHALL perform one shift-add step per cycle for exactly 24 cycles: if the multiplier LSB is 1, add the multiplicand to the accumulator; then shift the multiplicand left 1 and the multiplier right 1. It leaves to NORM on the 24th step.
REQ-008 NORM SHALL take one cycle and produce the result as follows:
- If product[47]=1, the mantissa is product[46:24] and the exponent is incremented by 1.
- Else the mantissa is product[45:23].
- Rounding is truncation (round toward zero).
REQ-009 NORM SHALL saturate the exponent as follows:
- Exponent ≥255: result = {sign, 8'hFF, 23'h0}.
- Exponent ≤0: result = {sign, 31'h0}.
- Otherwise result = {sign, exp[7:0], mantissa}. NORM then goes to DONE.
REQ-010 DONE SHALL last one cycle with done=1, then return to IDLE unconditionally.
REQ-011 Latency, counted from the edge that samples start to the first cycle in which done=1, SHALL be 1 cycle for the bypass and special paths and 26 cycles for the compute path.
REQ-012 start SHALL be ignored in MULT, NORM and DONE; operands and exc_* are not re-sampled and an in-flight operation is not disturbed.
REQ-013 busy SHALL be 1 exactly in MULT and NORM; done SHALL be 1 exactly in DONE; the two are never high together.
REQ-014 result SHALL change only on the edge entering DONE, and SHALL remain stable in IDLE.
REQ-015 Back-to-back operation SHALL work as follows: start held high continuously gives one accepted operation per pass through IDLE. The minimum issue interval is 2 cycles for bypass and 27 cycles for compute.

Reset
REQ-016 When rst=1 at a clock edge, the block SHALL set the state to IDLE and clear busy, done, result, the accumulator, the counter, the exponent and the sign to 0. This SHALL take precedence over start.
REQ-017 Reset asserted during MULT or NORM SHALL abort the operation: no done pulse follows and result reads 0.
REQ-018 After rst deasserts, the first start SHALL be accepted on the next edge.

Verification
REQ-019 Compute: A=0x3FC00000, B=0x40000000, exc_sel=1 -> done after 26 cycles, result=0x40400000; busy high for 25 cycles.
REQ-020 Sign: A=0xC0000000, B=0x40400000, exc_sel=1 -> result=0xC0C00000 at 26 cycles.
REQ-021 Bypass: exc_sel=0, exc_out=0x7F800000 -> done at 1 cycle, result=0x7F800000, busy never high.
REQ-022 Overflow/underflow:
- A=0x7F000000, B=0x40000000 -> result=0x7F800000.
- A=0x00800000, B=0x3F000000 -> result=0x00000000.
REQ-023 Specials: A=0x80000000, B=0x40000000, exc_sel=1 -> result=0x80000000 at 1 cycle.
REQ-024 Robustness: the bench SHALL check both of the following.
- Pulse start with new operands at cycle 5 of a compute -> ignored; the first result is unchanged.
- Assert rst at cycle 10 -> no done, result=0, and the next start completes normally.

Source files
------------

// File: rtl/fp_mul_seq_core.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_seq_core
// Description : Sequential IEEE-754 single-precision multiplier core.
//               Zero/infinity operands and exception-stage results take a
//               one-cycle path. Normal operands are multiplied by a 24-step
//               shift-add loop, then normalised with truncation and
//               saturating exponent handling.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               start           - request, sampled only while idle
//               float_num1/2    - operands A and B
//               exc_sel         - 0: forward exc_out, 1: compute product
//               exc_out         - exception-stage result
//               busy            - high while multiplying/normalising
//               done            - one-cycle pulse, result valid
//               result          - product, held until the next accepted start
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_seq_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] float_num1,
    input  logic [DATA_WIDTH-1:0] float_num2,
    input  logic                  exc_sel,
    input  logic [DATA_WIDTH-1:0] exc_out,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MULT = 2'd1;
    localparam logic [1:0] c_ST_NORM = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    logic [1:0]            r_state;
    logic                  r_sign;
    logic signed [9:0]     r_exp;
    logic [47:0]           r_mcand;
    logic [23:0]           r_mplier;
    logic [47:0]           r_acc;
    logic [4:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_busy;
    logic                  r_done;

    // Operand decode, evaluated on the inputs at the accepting edge
    logic                  w_sign_in;
    logic                  w_zero_in;
    logic                  w_inf_in;
    logic [9:0]            w_exp_in;

    assign w_sign_in = float_num1[31] ^ float_num2[31];
    assign w_zero_in = (float_num1[30:23] == 8'd0) || (float_num2[30:23] == 8'd0);
    assign w_inf_in  = (float_num1[30:23] == 8'hFF) || (float_num2[30:23] == 8'hFF);
    // Biased sum minus one bias; 10 bits signed covers -125..381 without wrap
    assign w_exp_in  = {2'b00, float_num1[30:23]} + {2'b00, float_num2[30:23]} - 10'd127;

    // Normalisation: the 1.x * 1.y product lies in [1,4), so at most one
    // right shift (exponent bump) is ever needed. Low bits are dropped.
    logic signed [9:0]     w_exp_norm;
    logic [22:0]           w_mant;
    logic [DATA_WIDTH-1:0] w_norm_result;

    always_comb begin
        w_exp_norm    = r_exp + (r_acc[47] ? 10'sd1 : 10'sd0);
        w_mant        = r_acc[47] ? r_acc[46:24] : r_acc[45:23];
        w_norm_result = {r_sign, w_exp_norm[7:0], w_mant};
        if (w_exp_norm >= 10'sd255) begin
            w_norm_result = {r_sign, 8'hFF, 23'd0};
        end else if (w_exp_norm <= 10'sd0) begin
            w_norm_result = {r_sign, 31'd0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_sign   <= 1'b0;
            r_exp    <= 10'sd0;
            r_mcand  <= 48'd0;
            r_mplier <= 24'd0;
            r_acc    <= 48'd0;
            r_cnt    <= 5'd0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        if (!exc_sel) begin
                            r_result <= exc_out;
                            r_done   <= 1'b1;
                            r_state  <= c_ST_DONE;
                        end else begin
                            r_sign <= w_sign_in;
                            // Zero outranks infinity; NaN payloads collapse to infinity
                            if (w_zero_in) begin
                                r_result <= {w_sign_in, 31'd0};
                                r_done   <= 1'b1;
                                r_state  <= c_ST_DONE;
                            end else if (w_inf_in) begin
                                r_result <= {w_sign_in, 8'hFF, 23'd0};
                                r_done   <= 1'b1;
                                r_state  <= c_ST_DONE;
                            end else begin
                                r_exp    <= $signed(w_exp_in);
                                r_mcand  <= {24'd0, 1'b1, float_num1[22:0]};
                                r_mplier <= {1'b1, float_num2[22:0]};
                                r_acc    <= 48'd0;
                                r_cnt    <= 5'd0;
                                r_busy   <= 1'b1;
                                r_state  <= c_ST_MULT;
                            end
                        end
                    end
                end
                c_ST_MULT: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 5'd1;
                    if (r_cnt == 5'd23) begin
                        r_state <= c_ST_NORM;
                    end
                end
                c_ST_NORM: begin
                    r_result <= w_norm_result;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= c_ST_DONE;
                end
                c_ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_seq_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_mul_seq_core
// Description : Scoreboard testbench for fp_mul_seq_core. A driver issues
//               directed and random operations and queues the expected
//               result, latency and busy length from an arithmetic reference
//               model; a monitor pops and compares on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_mul_seq_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] float_num1;
    logic [31:0] float_num2;
    logic        exc_sel;
    logic [31:0] exc_out;
    logic        busy;
    logic        done;
    logic [31:0] result;

    fp_mul_seq_core #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .float_num1 (float_num1),
        .float_num2 (float_num2),
        .exc_sel    (exc_sel),
        .exc_out    (exc_out),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          busy_len;
        int          issue;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic        rst_edge = 1'b0;
    int          busy_cnt = 0;
    logic [31:0] prev_result;
    exp_t        mon_e;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    // Reference model: real-number rules on integer mantissas
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          ea, eb, e;
        logic [63:0] pa, pb, p;
        logic [22:0] m;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 0 || eb == 0) return {s, 31'd0};
        if (ea == 255 || eb == 255) return {s, 8'hFF, 23'd0};
        pa = {40'd0, 1'b1, a[22:0]};
        pb = {40'd0, 1'b1, b[22:0]};
        p  = pa * pb;
        e  = ea + eb - 127;
        if (p >= 64'h0000_8000_0000_0000) begin
            e = e + 1;
            m = p[46:24];
        end else begin
            m = p[45:23];
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), m};
    endfunction

    function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'd0) || (b[30:23] == 8'd0) ||
               (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
    endfunction

    task automatic wait_idle(input string name);
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: actual no done required done within 100 cycles", name);
            sb_q.delete();
        end
    endtask

    task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic sel, input logic [31:0] eo, input bit wait_done);
        exp_t e;
        @(negedge clk);
        float_num1 = a;
        float_num2 = b;
        exc_sel    = sel;
        exc_out    = eo;
        start      = 1'b1;
        e.name     = name;
        e.res      = sel ? ref_mul(a, b) : eo;
        e.lat      = (!sel || is_special(a, b)) ? 1 : 26;
        e.busy_len = (e.lat == 26) ? 25 : 0;
        e.issue    = cyc;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        if (wait_done) wait_idle(name);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst_edge) busy_cnt = 0;
        else if (busy) busy_cnt++;
        n_checks++;
        if (busy && done) begin
            n_fail++;
            $display("FAIL busy_done_overlap: actual busy=1 done=1 required not both");
        end
        if (!done && !rst_edge) chk("result_stable", result, prev_result);
        if (done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: actual done=1 result %h required no done", result);
            end else begin
                mon_e = sb_q.pop_front();
                chk({mon_e.name, "_result"}, result, mon_e.res);
                chk({mon_e.name, "_latency"}, 32'(cyc - mon_e.issue), 32'(mon_e.lat));
                chk({mon_e.name, "_busy_cycles"}, 32'(busy_cnt), 32'(mon_e.busy_len));
            end
            busy_cnt = 0;
        end
        prev_result = result;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual simulation still running required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, b, eo;
        logic [7:0]  ea, eb;
        rst        = 1'b1;
        start      = 1'b0;
        float_num1 = '0;
        float_num2 = '0;
        exc_sel    = 1'b0;
        exc_out    = '0;
        repeat (3) @(negedge clk);
        chk("reset_result", result, 32'h0);
        chk("reset_busy", {31'd0, busy}, 32'h0);
        chk("reset_done", {31'd0, done}, 32'h0);
        rst = 1'b0;

        // Directed vectors
        issue("compute_1p5x2", 32'h3FC00000, 32'h40000000, 1'b1, 32'h0, 1'b1);
        chk("compute_1p5x2_abs", result, 32'h40400000);
        issue("sign", 32'hC0000000, 32'h40400000, 1'b1, 32'h0, 1'b1);
        chk("sign_abs", result, 32'hC0C00000);
        issue("bypass", 32'h3F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b1);
        chk("bypass_abs", result, 32'h7F800000);
        issue("overflow", 32'h7F000000, 32'h40000000, 1'b1, 32'h0, 1'b1);
        chk("overflow_abs", result, 32'h7F800000);
        issue("underflow", 32'h00800000, 32'h3F000000, 1'b1, 32'h0, 1'b1);
        chk("underflow_abs", result, 32'h00000000);
        issue("neg_zero", 32'h80000000, 32'h40000000, 1'b1, 32'h0, 1'b1);
        chk("neg_zero_abs", result, 32'h80000000);
        issue("inf_operand", 32'hFF800000, 32'h3F800000, 1'b1, 32'h0, 1'b1);
        issue("zero_beats_inf", 32'h7F800000, 32'h00000000, 1'b1, 32'h0, 1'b1);
        issue("bypass_b2b_1", 32'h0, 32'h0, 1'b0, 32'h12345678, 1'b1);
        issue("bypass_b2b_2", 32'h0, 32'h0, 1'b0, 32'h9ABCDEF0, 1'b1);

        // Start pulsed mid-compute must be ignored
        issue("ignore_start", 32'h40490FDB, 32'h402DF854, 1'b1, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        float_num1 = 32'h3F800000;
        float_num2 = 32'h3F800000;
        exc_sel    = 1'b0;
        exc_out    = 32'hDEADBEEF;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("ignore_start");
        repeat (5) @(negedge clk);

        // Reset mid-compute aborts with no done pulse
        issue("aborted", 32'h3FC00000, 32'h3FC00000, 1'b1, 32'h0, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        chk("abort_result", result, 32'h0);
        chk("abort_busy", {31'd0, busy}, 32'h0);
        chk("abort_done", {31'd0, done}, 32'h0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        issue("after_reset", 32'h3FC00000, 32'h3FC00000, 1'b1, 32'h0, 1'b1);
        chk("after_reset_abs", result, 32'h40100000);

        // Randomised operations
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: begin
                    ea = 8'($urandom_range(100, 154));
                    eb = 8'($urandom_range(100, 154));
                end
                1: begin
                    ea = 8'($urandom_range(1, 30));
                    eb = 8'($urandom_range(90, 127));
                end
                2: begin
                    ea = 8'($urandom_range(200, 254));
                    eb = 8'($urandom_range(127, 190));
                end
                default: begin
                    ea = a[30:23];
                    eb = b[30:23];
                end
            endcase
            a[30:23] = ea;
            b[30:23] = eb;
            eo = $urandom;
            issue("random", a, b, ($urandom_range(0, 4) != 0), eo, 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
